// File: rtl/fir_result_sink.sv
// fir_result_sink: rounds/saturates wide FIR results into OUT_W samples and
// buffers them in a first-word-fall-through FIFO with debug event counters.
`default_nettype none

module fir_result_sink #(
  parameter int IN_W  = 111,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  snk_data,
  input  logic             snk_valid,
  input  logic [1:0]       snk_error,
  output logic             snk_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clr_stats,
  output logic [15:0]      err_count,
  output logic [15:0]      sat_count,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_V = (CW+1)'(DEPTH);
  localparam logic [IN_W:0] ONE     = {{IN_W{1'b0}}, 1'b1};
  // Half an LSB of the shifted result; collapses to zero when SHIFT is 0.
  localparam logic signed [IN_W:0] RND  = $signed((ONE << SHIFT) >> 1);
  localparam logic signed [IN_W:0] MAXV = $signed({{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [IN_W:0] MINV = ~MAXV;

  logic                 rst_done;
  logic                 s1_valid;
  logic [OUT_W-1:0]     s1_data;
  logic [OUT_W-1:0]     mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;

  logic signed [IN_W:0] ext;
  logic signed [IN_W:0] rounded;
  logic signed [IN_W:0] shifted;
  logic                 clip_hi;
  logic                 clip_lo;
  logic [OUT_W-1:0]     conv;
  logic [CW:0]          fill;
  logic                 accept;
  logic                 push;
  logic                 pop;

  always_comb begin
    ext     = {snk_data[IN_W-1], snk_data};
    rounded = ext + RND;
    shifted = rounded >>> SHIFT;
    clip_hi = shifted > MAXV;
    clip_lo = shifted < MINV;
    if (clip_hi)
      conv = MAXV[OUT_W-1:0];
    else if (clip_lo)
      conv = MINV[OUT_W-1:0];
    else
      conv = shifted[OUT_W-1:0];
  end

  // The stage register holds a reserved slot, so it counts against free space.
  assign fill      = (CW+1)'(count) + (CW+1)'(s1_valid);
  assign snk_ready = rst_done && (fill < DEPTH_V);
  assign accept    = snk_valid && snk_ready;
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign push      = s1_valid;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_done  <= 1'b0;
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_count <= '0;
      sat_count <= '0;
      overflow  <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      s1_valid <= accept && (snk_error == 2'b00);
      if (accept && (snk_error == 2'b00))
        s1_data <= conv;

      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (clr_stats) begin
        err_count <= '0;
        sat_count <= '0;
        overflow  <= 1'b0;
      end else begin
        if (accept && (snk_error != 2'b00) && (err_count != 16'hFFFF))
          err_count <= err_count + 16'd1;
        if (accept && (snk_error == 2'b00) && (clip_hi || clip_lo) && (sat_count != 16'hFFFF))
          sat_count <= sat_count + 16'd1;
        if (snk_valid && !snk_ready)
          overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= s1_data;
  end

endmodule

`default_nettype wire

// File: tb/tb_fir_result_sink.sv
// tb_fir_result_sink: randomized and directed stimulus checked every cycle
// against a queue-based behavioural model of the sink.
`default_nettype none

module tb_fir_result_sink;

  localparam int IN_W  = 111;
  localparam int OUT_W = 16;
  localparam int SHIFT = 15;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [IN_W-1:0]  snk_data = '0;
  logic             snk_valid = 1'b0;
  logic [1:0]       snk_error = 2'b00;
  logic             snk_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             clr_stats = 1'b0;
  logic [15:0]      err_count;
  logic [15:0]      sat_count;
  logic             overflow;

  fir_result_sink #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_error(snk_error), .snk_ready(snk_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .clr_stats(clr_stats), .err_count(err_count), .sat_count(sat_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] mq[$];
  bit          ms1v;
  logic [15:0] ms1d;
  logic [15:0] merr;
  logic [15:0] msat;
  bit          movf;
  bit          mrd;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round half up then floor-divide by 2^SHIFT, then clamp to the sample range.
  function automatic logic [15:0] conv(input logic [IN_W-1:0] d, output bit clip);
    logic signed [127:0] x, p, q;
    x = {{(128-IN_W){d[IN_W-1]}}, d};
    p = 128'sd1 <<< SHIFT;
    x = x + p / 2;
    q = x / p;
    if (x < 0 && (x % p) != 0) q = q - 1;
    clip = 1'b0;
    if (q > 128'sd32767) begin
      clip = 1'b1;
      return 16'h7FFF;
    end
    if (q < -128'sd32768) begin
      clip = 1'b1;
      return 16'h8000;
    end
    return q[15:0];
  endfunction

  function automatic logic [IN_W-1:0] rnd_data();
    logic [127:0]           r;
    logic signed [IN_W-1:0] s;
    r = {$urandom, $urandom, $urandom, $urandom};
    s = r[IN_W-1:0];
    return s >>> $urandom_range(0, IN_W-1);
  endfunction

  task automatic model_reset();
    mq.delete();
    ms1v = 1'b0; ms1d = '0; merr = '0; msat = '0; movf = 1'b0; mrd = 1'b0;
  endtask

  // One clock: check outputs at the falling edge, drive inputs, advance model.
  task automatic step(input bit v, input logic [IN_W-1:0] d, input logic [1:0] e,
                      input bit ordy, input bit clr);
    bit          rdy, pop, clip, acc;
    logic [15:0] cv;
    @(negedge clk);
    rdy = mrd && ((mq.size() + int'(ms1v)) < DEPTH);
    chk("snk_ready", snk_ready, rdy);
    chk("out_valid", out_valid, mq.size() != 0);
    chk("out_data", out_data, (mq.size() != 0) ? mq[0] : 16'h0);
    chk("err_count", err_count, merr);
    chk("sat_count", sat_count, msat);
    chk("overflow", overflow, movf);
    snk_valid = v; snk_data = d; snk_error = e; out_ready = ordy; clr_stats = clr;
    pop = (mq.size() != 0) && ordy;
    acc = v && rdy;
    cv  = conv(d, clip);
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (ms1v) mq.push_back(ms1d);
    ms1v = acc && (e == 2'b00);
    ms1d = cv;
    if (clr) begin
      merr = '0; msat = '0; movf = 1'b0;
    end else begin
      if (acc && e != 2'b00 && merr != 16'hFFFF) merr++;
      if (acc && e == 2'b00 && clip && msat != 16'hFFFF) msat++;
      if (v && !rdy) movf = 1'b1;
    end
    mrd = 1'b1;
  endtask

  task automatic idle(input bit ordy, input bit clr);
    step(1'b0, '0, 2'b00, ordy, clr);
  endtask

  logic [IN_W-1:0] dv [5];
  logic [15:0]     ev [5];
  logic [IN_W-1:0] t;
  bit              cl;

  initial begin
    t = '0; t[40] = 1'b1;
    dv[0] = IN_W'(32'h8000);
    dv[1] = IN_W'(32'h7FFF);
    dv[2] = -IN_W'(32'h8001);
    dv[3] = t;
    dv[4] = -t;
    ev[0] = 16'h0001; ev[1] = 16'h0001; ev[2] = 16'hFFFF; ev[3] = 16'h7FFF; ev[4] = 16'h8000;
    for (int i = 0; i < 5; i++) chk("model_conv", conv(dv[i], cl), ev[i]);

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_snk_ready", snk_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 16'h0);
    rst = 1'b1;

    // First post-reset cycle is never ready, so a valid there is lost.
    step(1'b1, IN_W'(32'h1234), 2'b00, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    #1;
    chk("first_cycle_overflow", overflow, 1'b1);
    chk("first_cycle_no_output", out_valid, 1'b0);
    idle(1'b1, 1'b1);
    #1;
    chk("clr_overflow", overflow, 1'b0);

    for (int i = 0; i < 5; i++) step(1'b1, dv[i], 2'b00, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    #1;
    chk("sat_count_two", sat_count, 16'd2);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("directed_conv", out_data, ev[i]);
      idle(1'b1, 1'b0);
    end

    idle(1'b1, 1'b1);
    step(1'b1, '0, 2'b01, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    #1;
    chk("err_count_one", err_count, 16'd1);
    chk("err_no_output", out_valid, 1'b0);
    for (int i = 0; i < 65540; i++) step(1'b1, '0, 2'b01, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    #1;
    chk("err_count_sat", err_count, 16'hFFFF);

    idle(1'b1, 1'b1);
    for (int i = 1; i <= 10; i++) step(1'b1, IN_W'(i) << SHIFT, 2'b00, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    #1;
    chk("full_not_ready", snk_ready, 1'b0);
    chk("full_overflow", overflow, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      #1;
      chk("drain_order", out_data, 16'(i));
      idle(1'b1, 1'b0);
    end
    #1;
    chk("drained_empty", out_valid, 1'b0);

    for (int i = 0; i < 10; i++) step(1'b1, rnd_data(), 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, rnd_data(), 2'b00, 1'b1, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        @(negedge clk);
        rst = 1'b0;
        snk_valid = 1'b0; out_ready = 1'b0; clr_stats = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_snk_ready", snk_ready, 1'b0);
        chk("midrst_out_data", out_data, 16'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
      end
      step($urandom_range(0, 3) != 0, rnd_data(),
           ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
           $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
    end
    idle(1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
